mips_multicycle_control: RTL and testbench

//  Main control FSM of the multicycle MIPS datapath. Decodes the IR opcode and sequences

---
 rtl/mips_ctrl_pkg.sv | 46 ++++
 rtl/mips_multicycle_control.sv | 178 +++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS main control FSM.
// This file holds the opcodes, the state encoding and the select codes for the datapath.
package mips_ctrl_pkg;

  // IR[31:26] opcodes recognised by the controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // alu_op codes consumed by the ALU control stage
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // alu_src_b select codes
  localparam logic [1:0] ASB_B       = 2'b00;
  localparam logic [1:0] ASB_FOUR    = 2'b01;
  localparam logic [1:0] ASB_IMM     = 2'b10;
  localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

  // pc_source select codes
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // Controller states. Encodings 13..15 are unreachable and recover to FETCH.
  typedef enum logic [3:0] {
    RESET     = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    EXEC      = 4'd3,
    R_WB      = 4'd4,
    MEM_ADDR  = 4'd5,
    MEM_READ  = 4'd6,
    MEM_WB    = 4'd7,
    MEM_WRITE = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    ADDI_EXEC = 4'd11,
    ADDI_WB   = 4'd12
  } state_t;

endpackage

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath.
// It sequences fetch, decode, execute, memory and writeback, and it drives every datapath enable.
//
// Memory handshake: a request (mem_read or mem_write) is held steady
// while the FSM sits in FETCH, MEM_READ or MEM_WRITE. The access completes
// in the cycle where mem_ready=1. In that cycle the FSM advances and any
// completion-qualified enables (ir_write, pc_write, instr_done on a store)
// assert. mem_ready is ignored in every other state.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op
);

  // Current state is kept as a named internal signal so checkers can bind to it.
  state_t state;
  state_t next_state;

  // State register; asynchronous reset forces RESET (all outputs 0) immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET;
    else        state <= next_state;
  end

  // Next-state and output decode; every output defaults to 0
  always_comb begin
    next_state    = FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ASB_B;
    alu_op        = ALUOP_ADD;
    pc_source     = PCS_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    case (state)
      RESET: next_state = FETCH;

      FETCH: begin
        // PC+4 is computed every fetch cycle; PC and IR load only on completion
        mem_read   = 1'b1;
        i_or_d     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ASB_FOUR;
        alu_op     = ALUOP_ADD;
        pc_source  = PCS_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        next_state = mem_ready ? DECODE : FETCH;
      end

      DECODE: begin
        // Speculatively compute the branch target into ALUOut
        alu_src_a = 1'b0;
        alu_src_b = ASB_IMM_SH2;
        alu_op    = ALUOP_ADD;
        case (opcode)
          OP_RTYPE:      next_state = EXEC;
          OP_LW, OP_SW:  next_state = MEM_ADDR;
          OP_BEQ:        next_state = BRANCH;
          OP_J:          next_state = JUMP;
          OP_ADDI:       next_state = ADDI_EXEC;
          default: begin
            next_state = FETCH;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end

      EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = ASB_B;
        alu_op     = ALUOP_FUNCT;
        next_state = R_WB;
      end

      R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = 1'b0;
        instr_done = 1'b1;
        next_state = FETCH;
      end

      MEM_ADDR: begin
        // IR still holds the opcode, so lw/sw can be told apart here
        alu_src_a  = 1'b1;
        alu_src_b  = ASB_IMM;
        alu_op     = ALUOP_ADD;
        next_state = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end

      MEM_READ: begin
        mem_read   = 1'b1;
        i_or_d     = 1'b1;
        next_state = mem_ready ? MEM_WB : MEM_READ;
      end

      MEM_WB: begin
        reg_dst    = 1'b0;
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
      end

      MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        next_state = mem_ready ? FETCH : MEM_WRITE;
      end

      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = ASB_B;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
        instr_done    = 1'b1;
        next_state    = FETCH;
      end

      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCS_JUMP;
        instr_done = 1'b1;
        next_state = FETCH;
      end

      ADDI_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = ASB_IMM;
        alu_op     = ALUOP_ADD;
        next_state = ADDI_WB;
      end

      ADDI_WB: begin
        reg_dst    = 1'b0;
        reg_write  = 1'b1;
        mem_to_reg = 1'b0;
        instr_done = 1'b1;
        next_state = FETCH;
      end

      // Unreachable encodings: outputs stay 0 and control recovers to FETCH
      default: next_state = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed testbench for mips_multicycle_control.
// Every output is packed into one vector and compared with hand-built expected words.
module tb_mips_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done, illegal_op;

  int vectors;
  int miscompares;

  mips_multicycle_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output word layout:
  // pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb[2], aop[2], pcs[2], done, ill
  function automatic logic [17:0] ov(
    input logic pcw, input logic pcwc, input logic iord, input logic mr,
    input logic mw, input logic irw, input logic m2r, input logic rdst,
    input logic rw, input logic asa, input logic [1:0] asb, input logic [1:0] aop,
    input logic [1:0] pcs, input logic done, input logic ill);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, pcs, done, ill};
  endfunction

  logic [17:0] e_zero, e_fetch_rdy, e_fetch_wait, e_decode, e_decode_ill, e_exec, e_rwb;
  logic [17:0] e_maddr, e_mread, e_mwb, e_mwrite_wait, e_mwrite_rdy, e_branch, e_jump;
  logic [17:0] e_aexec, e_awb;

  initial begin
    e_zero        = '0;
    e_fetch_rdy   = ov(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    e_fetch_wait  = ov(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    e_decode      = ov(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
    e_decode_ill  = ov(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1,1);
    e_exec        = ov(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
    e_rwb         = ov(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0);
    e_maddr       = ov(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
    e_mread       = ov(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    e_mwb         = ov(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0);
    e_mwrite_wait = ov(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    e_mwrite_rdy  = ov(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1,0);
    e_branch      = ov(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
    e_jump        = ov(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0);
    e_aexec       = ov(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
    e_awb         = ov(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0);
  end

  // Driver tasks
  // Move to 1 ns after the next rising edge; inputs are driven from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, then compare all outputs and the exclusivity rules.
  task automatic chk(input string tag, input logic [17:0] exp);
    logic [17:0] obs;
    #1;
    obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
           illegal_op};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    vectors++;
    assert ((mem_read & mem_write) === 1'b0 && (reg_write & mem_write) === 1'b0) else begin
      miscompares++;
      $error("FAIL %s_excl observed mr=%b mw=%b rw=%b expected no overlap",
             tag, mem_read, mem_write, reg_write);
    end
  endtask

  // Directed sequence
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    opcode      = 6'b000000;
    mem_ready   = 1'b1;
    #2;
    chk("reset_hold", e_zero);
    tick();
    chk("reset_hold_edge", e_zero);
    rst_n = 1'b1;
    chk("reset_release", e_zero);

    // lw: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB
    tick(); opcode = 6'b100011; chk("lw_fetch", e_fetch_rdy);
    tick(); chk("lw_decode", e_decode);
    tick(); chk("lw_maddr", e_maddr);
    tick(); chk("lw_mread", e_mread);
    tick(); chk("lw_mwb", e_mwb);

    // R-type: FETCH, DECODE, EXEC, R_WB
    tick(); opcode = 6'b000000; chk("r_fetch", e_fetch_rdy);
    tick(); chk("r_decode", e_decode);
    tick(); chk("r_exec", e_exec);
    tick(); chk("r_wb", e_rwb);

    // addi: FETCH, DECODE, ADDI_EXEC, ADDI_WB
    tick(); opcode = 6'b001000; chk("addi_fetch", e_fetch_rdy);
    tick(); chk("addi_decode", e_decode);
    tick(); chk("addi_exec", e_aexec);
    tick(); chk("addi_wb", e_awb);

    // beq: mem_ready low in DECODE must not stall
    tick(); opcode = 6'b000100; chk("beq_fetch", e_fetch_rdy);
    tick(); mem_ready = 1'b0; chk("beq_decode_nordy", e_decode);
    tick(); mem_ready = 1'b1; chk("beq_branch", e_branch);

    // j
    tick(); opcode = 6'b000010; chk("j_fetch", e_fetch_rdy);
    tick(); chk("j_decode", e_decode);
    tick(); chk("j_jump", e_jump);

    // sw with 3 wait cycles in FETCH and 3 in MEM_WRITE
    tick(); opcode = 6'b101011; mem_ready = 1'b0; chk("sw_fetch_wait1", e_fetch_wait);
    tick(); chk("sw_fetch_wait2", e_fetch_wait);
    tick(); chk("sw_fetch_wait3", e_fetch_wait);
    mem_ready = 1'b1; chk("sw_fetch_rdy", e_fetch_rdy);
    tick(); chk("sw_decode", e_decode);
    tick(); chk("sw_maddr", e_maddr);
    tick(); mem_ready = 1'b0; chk("sw_mwrite_wait1", e_mwrite_wait);
    tick(); chk("sw_mwrite_wait2", e_mwrite_wait);
    tick(); chk("sw_mwrite_wait3", e_mwrite_wait);
    mem_ready = 1'b1; chk("sw_mwrite_rdy", e_mwrite_rdy);

    // illegal opcode
    tick(); opcode = 6'b111111; chk("ill_fetch", e_fetch_rdy);
    tick(); chk("ill_decode", e_decode_ill);
    tick(); opcode = 6'b100011; chk("ill_back_fetch", e_fetch_rdy);

    // lw stalled in MEM_READ, then reset asserted between clock edges
    tick(); chk("rst_lw_decode", e_decode);
    tick(); chk("rst_lw_maddr", e_maddr);
    tick(); mem_ready = 1'b0; chk("rst_lw_mread_wait", e_mread);
    tick(); chk("rst_lw_mread_wait2", e_mread);
    #2; rst_n = 1'b0; chk("rst_async_now", e_zero);
    tick(); chk("rst_async_held", e_zero);
    rst_n = 1'b1; chk("rst_release_reset", e_zero);
    tick(); mem_ready = 1'b1; chk("rst_release_fetch", e_fetch_rdy);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
